// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared light codes, state codes and decode helper for the intersection controller.
package traffic_phase_ctrl_pkg;

    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        ST_A_GRN  = 4'd0,
        ST_A_Y1   = 4'd1,
        ST_A_LEFT = 4'd2,
        ST_A_Y2   = 4'd3,
        ST_B_GRN  = 4'd4,
        ST_B_Y1   = 4'd5,
        ST_B_LEFT = 4'd6,
        ST_B_Y2   = 4'd7,
        ST_FLASH  = 4'd8
    } state_e;

    localparam logic [1:0] LT_RED  = 2'b00;
    localparam logic [1:0] LT_GRN  = 2'b01;
    localparam logic [1:0] LT_RGT  = 2'b10;
    localparam logic [1:0] LT_LEFT = 2'b11;

    // Car light of the running axis from the low two state bits (GRN/Y1/LEFT/Y2).
    function automatic logic [1:0] car_code(input logic [1:0] sub);
        case (sub)
            2'd0:    car_code = LT_GRN;
            2'd2:    car_code = LT_LEFT;
            default: car_code = LT_RGT;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_tick_gen.sv
// Tick divider: one tick every TICK_DIV enabled clocks; frozen while disabled.
module traffic_tick_gen #(
    parameter int TICK_DIV = 1,
    parameter int CNT_W    = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    logic [CNT_W-1:0] div_q, div_d;
    logic             wrap;

    assign wrap   = (div_q == CNT_W'(TICK_DIV - 1));
    assign o_tick = i_en & wrap;

    always_comb begin
        div_d = div_q;
        if (i_clr) begin
            div_d = '0;
        end else if (i_en) begin
            div_d = wrap ? '0 : div_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-axis intersection controller: car phase FSM, ped request latching, night flash.
//
// state     | meaning
// A_GRN     | axis A green, B peds may walk
// A_Y1      | axis A right/yellow before left turn
// A_LEFT    | axis A left-turn arrow
// A_Y2      | axis A right/yellow before switching to B
// B_*       | same four phases for axis B, A peds may walk
// FLASH     | night flash, both axes blink yellow
module traffic_phase_ctrl
    import traffic_phase_ctrl_pkg::*;
#(
    parameter int T_GREEN  = 20,
    parameter int T_YEL    = 2,
    parameter int T_LEFT   = 10,
    parameter int T_WALK   = 14,
    parameter int T_FLASH  = 6,
    parameter int PED_AUTO = 1,
    parameter int TICK_DIV = 1,
    parameter int CNT_W    = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_flash,
    input  logic [1:0]       i_ped_req,
    output logic [1:0]       o_car_a,
    output logic [1:0]       o_car_b,
    output logic [1:0]       o_ped_a,
    output logic [1:0]       o_ped_b,
    output logic [ST_W-1:0]  o_state,
    output logic [CNT_W-1:0] o_axis_cnt
);

    localparam int T_AXIS = T_GREEN + 2 * T_YEL + T_LEFT;
    localparam logic [CNT_W-1:0] C_Y1    = CNT_W'(T_GREEN);
    localparam logic [CNT_W-1:0] C_LEFT  = CNT_W'(T_GREEN + T_YEL);
    localparam logic [CNT_W-1:0] C_Y2    = CNT_W'(T_GREEN + T_YEL + T_LEFT);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(T_AXIS - 1);
    localparam logic [CNT_W-1:0] C_WALK  = CNT_W'(T_WALK);
    localparam logic [CNT_W-1:0] C_PFLSH = CNT_W'(T_WALK + T_FLASH);
    localparam logic             PA      = (PED_AUTO != 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]       req_lat_q, req_lat_d;
    logic [1:0]       grant_q, grant_d;
    logic             blink_q, blink_d;
    logic             tick, div_clr;
    logic [1:0]       ped_code;

    traffic_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (i_start),
        .i_clr  (div_clr),
        .o_tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_A_GRN;
            cnt_q     <= '0;
            req_lat_q <= '0;
            grant_q   <= {PA, 1'b0};
            blink_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_lat_q <= req_lat_d;
            grant_q   <= grant_d;
            blink_q   <= blink_d;
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Grant index k is the ped group about to walk: [0] A peds (B running), [1] B peds.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_lat_d = req_lat_q | i_ped_req;
        grant_d   = grant_q;
        blink_d   = blink_q;
        div_clr   = 1'b0;
        if (i_flash && state_q != ST_FLASH) begin
            state_d = ST_FLASH;
            cnt_d   = '0;
            blink_d = 1'b0;
        end else if (!i_flash && state_q == ST_FLASH) begin
            state_d      = ST_A_GRN;
            cnt_d        = '0;
            div_clr      = 1'b1;
            grant_d[1]   = PA | req_lat_q[1] | i_ped_req[1];
            req_lat_d[1] = 1'b0;
        end else if (tick) begin
            if (state_q == ST_FLASH) begin
                blink_d = ~blink_q;
            end else if (cnt_q == C_LAST) begin
                cnt_d = '0;
                if (state_q[2]) begin
                    state_d      = ST_A_GRN;
                    grant_d[1]   = PA | req_lat_q[1] | i_ped_req[1];
                    req_lat_d[1] = 1'b0;
                end else begin
                    state_d      = ST_B_GRN;
                    grant_d[0]   = PA | req_lat_q[0] | i_ped_req[0];
                    req_lat_d[0] = 1'b0;
                end
            end else begin
                cnt_d = cnt_inc;
                if (cnt_inc == C_Y1 || cnt_inc == C_LEFT || cnt_inc == C_Y2) begin
                    state_d = state_e'(state_q + 4'd1);
                end
            end
        end
    end

    always_comb begin
        ped_code = LT_RED;
        if (cnt_q < C_WALK) begin
            ped_code = LT_GRN;
        end else if (cnt_q < C_PFLSH) begin
            ped_code = {1'b0, cnt_q[0]};
        end
    end

    always_comb begin
        o_car_a    = LT_RED;
        o_car_b    = LT_RED;
        o_ped_a    = LT_RED;
        o_ped_b    = LT_RED;
        o_state    = state_q;
        o_axis_cnt = cnt_q;
        if (state_q == ST_FLASH) begin
            o_car_a = {blink_q, 1'b0};
            o_car_b = {blink_q, 1'b0};
        end else if (!state_q[2]) begin
            o_car_a = car_code(state_q[1:0]);
            o_ped_b = grant_q[1] ? ped_code : LT_RED;
        end else begin
            o_car_b = car_code(state_q[1:0]);
            o_ped_a = grant_q[0] ? ped_code : LT_RED;
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench: three controller variants (default, PED_AUTO=0, TICK_DIV=4) against a phase-table model.
module tb_traffic_phase_ctrl;

    localparam int NI = 3;
    localparam int TG = 20, TY = 2, TL = 10, TW = 14, TF = 6;
    localparam int TA = TG + 2 * TY + TL;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_flash = 1'b0;
    logic [1:0] i_ped_req = 2'b00;

    logic [1:0] car_a [NI];
    logic [1:0] car_b [NI];
    logic [1:0] ped_a [NI];
    logic [1:0] ped_b [NI];
    logic [3:0] st    [NI];
    logic [6:0] cnt   [NI];
    logic [18:0] obs  [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    traffic_phase_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_flash(i_flash), .i_ped_req(i_ped_req),
        .o_car_a(car_a[0]), .o_car_b(car_b[0]), .o_ped_a(ped_a[0]), .o_ped_b(ped_b[0]),
        .o_state(st[0]), .o_axis_cnt(cnt[0]));

    traffic_phase_ctrl #(.PED_AUTO(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_flash(i_flash), .i_ped_req(i_ped_req),
        .o_car_a(car_a[1]), .o_car_b(car_b[1]), .o_ped_a(ped_a[1]), .o_ped_b(ped_b[1]),
        .o_state(st[1]), .o_axis_cnt(cnt[1]));

    traffic_phase_ctrl #(.TICK_DIV(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_flash(i_flash), .i_ped_req(i_ped_req),
        .o_car_a(car_a[2]), .o_car_b(car_b[2]), .o_ped_a(ped_a[2]), .o_ped_b(ped_b[2]),
        .o_state(st[2]), .o_axis_cnt(cnt[2]));

    for (genvar g = 0; g < NI; g++) begin : g_obs
        assign obs[g] = {st[g], cnt[g], car_a[g], car_b[g], ped_a[g], ped_b[g]};
    end

    function automatic int pa_of(int k);
        return (k == 1) ? 0 : 1;
    endfunction

    function automatic int td_of(int k);
        return (k == 2) ? 4 : 1;
    endfunction

    // Model: position in the 2*TA tick cycle plus pending requests and grants per ped group.
    int         m_t   [NI];
    int         m_div [NI];
    logic [1:0] m_lat [NI];
    logic [1:0] m_gr  [NI];
    bit         m_fl  [NI];
    bit         m_bl  [NI];

    always @(posedge clk or negedge rst_n) begin : mdl
        logic [1:0] nl;
        bit         tk;
        int         p;
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                m_t[k] = 0; m_div[k] = 0; m_lat[k] = 2'b00;
                m_gr[k] = {pa_of(k) != 0, 1'b0}; m_fl[k] = 0; m_bl[k] = 0;
            end else begin
                nl = m_lat[k] | i_ped_req;
                tk = i_start && (m_div[k] == td_of(k) - 1);
                if (i_start) m_div[k] = tk ? 0 : m_div[k] + 1;
                if (i_flash && !m_fl[k]) begin
                    m_fl[k] = 1; m_t[k] = 0; m_bl[k] = 0;
                end else if (!i_flash && m_fl[k]) begin
                    m_fl[k] = 0; m_t[k] = 0; m_div[k] = 0;
                    m_gr[k][1] = (pa_of(k) != 0) | m_lat[k][1] | i_ped_req[1];
                    nl[1] = 1'b0;
                end else if (m_fl[k]) begin
                    if (tk) m_bl[k] = !m_bl[k];
                end else if (tk) begin
                    m_t[k] = (m_t[k] + 1) % (2 * TA);
                    if (m_t[k] % TA == 0) begin
                        p = (m_t[k] == TA) ? 0 : 1;
                        m_gr[k][p] = (pa_of(k) != 0) | m_lat[k][p] | i_ped_req[p];
                        nl[p] = 1'b0;
                    end
                end
                m_lat[k] = nl;
            end
        end
    end

    function automatic logic [18:0] mdl_out(int k);
        int ax, c, sub, car, ped;
        if (m_fl[k]) return {4'd8, 7'd0, m_bl[k], 1'b0, m_bl[k], 1'b0, 4'b0000};
        ax  = m_t[k] / TA;
        c   = m_t[k] % TA;
        sub = (c < TG) ? 0 : (c < TG + TY) ? 1 : (c < TG + TY + TL) ? 2 : 3;
        car = (sub == 0) ? 1 : (sub == 2) ? 3 : 2;
        if (!m_gr[k][1 - ax])  ped = 0;
        else if (c < TW)       ped = 1;
        else if (c < TW + TF)  ped = c % 2;
        else                   ped = 0;
        if (ax == 0) return {4'(sub), 7'(c), 2'(car), 2'b00, 2'b00, 2'(ped)};
        return {4'(4 + sub), 7'(c), 2'b00, 2'(car), 2'(ped), 2'b00};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; i_start = 1'b0; i_flash = 1'b0; i_ped_req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1; i_start = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; i_start = 1'b0; i_flash = 1'b0; i_ped_req = 2'b00;
        @(negedge clk);
        total++;
        if (obs[0] !== {4'd0, 7'd0, 2'b01, 2'b00, 2'b00, 2'b01}) begin
            bad++; $display("FAIL reset_dut0 got=%h exp=%h", obs[0], {4'd0, 7'd0, 2'b01, 2'b00, 2'b00, 2'b01});
        end
        total++;
        if (ped_b[1] !== 2'b00) begin
            bad++; $display("FAIL reset_ped_b_noauto got=%b exp=00", ped_b[1]);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            total++;
            if (obs[k] !== mdl_out(k)) begin
                bad++; $display("FAIL reset_idle_%0d got=%h exp=%h", k, obs[k], mdl_out(k));
            end
        end
    endtask

    task automatic test_sequence();
        logic [1:0] e;
        do_reset();
        total++;
        if (car_a[0] !== 2'b01 || ped_b[0] !== 2'b01) begin
            bad++; $display("FAIL seq_tick0 got=%b/%b exp=01/01", car_a[0], ped_b[0]);
        end
        for (int n = 1; n <= 140; n++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                total++;
                if (obs[k] !== mdl_out(k)) begin
                    bad++; $display("FAIL seq_model_%0d n=%0d got=%h exp=%h", k, n, obs[k], mdl_out(k));
                end
            end
            case (n)
                20, 32: begin
                    total++;
                    if (car_a[0] !== 2'b10) begin bad++; $display("FAIL seq_yel n=%0d got=%b exp=10", n, car_a[0]); end
                end
                22: begin
                    total++;
                    if (car_a[0] !== 2'b11) begin bad++; $display("FAIL seq_left got=%b exp=11", car_a[0]); end
                end
                34: begin
                    total++;
                    if ({car_a[0], car_b[0], ped_a[0], ped_b[0]} !== 8'b00_01_01_00) begin
                        bad++; $display("FAIL seq_switch got=%b exp=00010100", {car_a[0], car_b[0], ped_a[0], ped_b[0]});
                    end
                end
                68: begin
                    total++;
                    if (st[0] !== 4'd0 || cnt[0] !== 7'd0) begin
                        bad++; $display("FAIL seq_wrap got=%0d/%0d exp=0/0", st[0], cnt[0]);
                    end
                end
                default: ;
            endcase
            if (n >= 14 && n <= 21) begin
                e = (n < 20 && n % 2 == 1) ? 2'b01 : 2'b00;
                total++;
                if (ped_b[0] !== e) begin bad++; $display("FAIL seq_pedflash n=%0d got=%b exp=%b", n, ped_b[0], e); end
            end
            if (n < 34) begin
                total++;
                if (ped_b[1] !== 2'b00) begin bad++; $display("FAIL seq_noauto_pedb n=%0d got=%b exp=00", n, ped_b[1]); end
            end
        end
    endtask

    task automatic test_hold();
        int guard = 0;
        do_reset();
        while (m_t[0] != 10 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 100) begin bad++; $display("FAIL hold_reach got=%0d exp=10", m_t[0]); end
        i_start = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            total++;
            if (obs[0] !== {4'd0, 7'd10, 2'b01, 2'b00, 2'b00, 2'b01}) begin
                bad++; $display("FAIL hold_frozen n=%0d got=%h exp=%h", n, obs[0], {4'd0, 7'd10, 2'b01, 2'b00, 2'b00, 2'b01});
            end
        end
        total++;
        if (obs[2] !== mdl_out(2)) begin bad++; $display("FAIL hold_div4 got=%h exp=%h", obs[2], mdl_out(2)); end
        i_start = 1'b1;
        @(negedge clk);
        total++;
        if (cnt[0] !== 7'd11) begin bad++; $display("FAIL hold_resume got=%0d exp=11", cnt[0]); end
    endtask

    task automatic test_ped_req();
        do_reset();
        for (int n = 1; n <= 140; n++) begin
            @(negedge clk);
            total++;
            if (obs[1] !== mdl_out(1)) begin bad++; $display("FAIL ped_model n=%0d got=%h exp=%h", n, obs[1], mdl_out(1)); end
            if (n < 34) begin
                total++;
                if (ped_b[1] !== 2'b00) begin bad++; $display("FAIL ped_nogrant_b n=%0d got=%b exp=00", n, ped_b[1]); end
            end
            if (n == 34) begin
                total++;
                if (ped_a[1] !== 2'b01) begin bad++; $display("FAIL ped_granted_a got=%b exp=01", ped_a[1]); end
            end
            if (n >= 68 && n <= 135 && n != 102) begin
                total++;
                if (ped_a[1] !== 2'b00) begin bad++; $display("FAIL ped_cleared_a n=%0d got=%b exp=00", n, ped_a[1]); end
            end
            if (n == 102) begin
                total++;
                if (ped_a[1] !== 2'b00 || ped_a[0] !== 2'b01) begin
                    bad++; $display("FAIL ped_second_b got=%b/%b exp=00/01", ped_a[1], ped_a[0]);
                end
            end
            i_ped_req = (n == 5) ? 2'b01 : 2'b00;
        end
    endtask

    task automatic test_flash();
        do_reset();
        repeat (25) @(negedge clk);
        i_flash = 1'b1;
        @(negedge clk);
        total++;
        if (obs[0] !== {4'd8, 7'd0, 8'h00}) begin bad++; $display("FAIL flash_enter got=%h exp=%h", obs[0], {4'd8, 7'd0, 8'h00}); end
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            total++;
            if (car_a[0] !== {n[0], 1'b0} || car_b[0] !== {n[0], 1'b0} || {ped_a[0], ped_b[0]} !== 4'b0000) begin
                bad++; $display("FAIL flash_blink n=%0d got=%b%b%b%b exp=%b", n, car_a[0], car_b[0], ped_a[0], ped_b[0], {n[0], 1'b0, n[0], 5'b0});
            end
            for (int k = 1; k < NI; k++) begin
                total++;
                if (obs[k] !== mdl_out(k)) begin bad++; $display("FAIL flash_model_%0d got=%h exp=%h", k, obs[k], mdl_out(k)); end
            end
        end
        i_flash = 1'b0;
        @(negedge clk);
        total++;
        if (st[0] !== 4'd0 || car_a[0] !== 2'b01 || cnt[0] !== 7'd0) begin
            bad++; $display("FAIL flash_exit got=%0d/%b/%0d exp=0/01/0", st[0], car_a[0], cnt[0]);
        end
        repeat (5) @(negedge clk);
        total++;
        if (obs[2] !== mdl_out(2)) begin bad++; $display("FAIL flash_exit_div4 got=%h exp=%h", obs[2], mdl_out(2)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            i_ped_req = (n == 36) ? 2'b01 : 2'b00;
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (obs[0] !== {4'd0, 7'd0, 2'b01, 2'b00, 2'b00, 2'b01} || ped_b[1] !== 2'b00) begin
            bad++; $display("FAIL rstmid_async got=%h exp=%h", obs[0], {4'd0, 7'd0, 2'b01, 2'b00, 2'b00, 2'b01});
        end
        #1 rst_n = 1'b1;
        for (int n = 1; n <= 34; n++) begin
            @(negedge clk);
            if (n == 1) begin
                total++;
                if (st[0] !== 4'd0 || cnt[0] !== 7'd1) begin bad++; $display("FAIL rstmid_restart got=%0d/%0d exp=0/1", st[0], cnt[0]); end
            end
        end
        total++;
        if (ped_a[1] !== 2'b00 || st[1] !== 4'd4) begin
            bad++; $display("FAIL rstmid_latch got=%b/%0d exp=00/4", ped_a[1], st[1]);
        end
    endtask

    task automatic test_tick_div();
        int e;
        do_reset();
        for (int c = 1; c <= 272; c++) begin
            @(negedge clk);
            e = (c / 4) % (2 * TA);
            total++;
            if (cnt[2] !== 7'(e % TA)) begin bad++; $display("FAIL div4_cnt c=%0d got=%0d exp=%0d", c, cnt[2], e % TA); end
            if (c == 79 || c == 80) begin
                total++;
                if (car_a[2] !== ((c == 80) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL div4_yel c=%0d got=%b", c, car_a[2]); end
            end
            if (c == 271 || c == 272) begin
                total++;
                if (st[2] !== ((c == 272) ? 4'd0 : 4'd7)) begin bad++; $display("FAIL div4_wrap c=%0d got=%0d", c, st[2]); end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                total++;
                if (obs[k] !== mdl_out(k)) begin
                    bad++; $display("FAIL rand_model_%0d n=%0d got=%h exp=%h", k, n, obs[k], mdl_out(k));
                end
            end
            i_start   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) i_flash = ~i_flash;
            i_ped_req = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
        end
        i_flash = 1'b0;
        i_ped_req = 2'b00;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_hold();
        test_ped_req();
        test_flash();
        test_reset_mid();
        test_tick_div();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
